// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neural-network datapath blocks.
//   state_t    : FSM encoding for layer_21_mac (IDLE=0, MAC=1, DONE=2)
//   acc_width  : accumulator width that cannot overflow for a 3-term MAC
//   fit_width  : reduce a wide signed value to out_w bits, either saturating
//                or wrapping (two's complement), result sign-extended to WIDE_W
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDE_W = 64;

    // Full product width plus two guard bits covers the sum of three products.
    function automatic int acc_width(input int in_w, input int w_w);
        return in_w + w_w + 2;
    endfunction

    function automatic logic signed [WIDE_W-1:0] fit_width(
        input logic signed [WIDE_W-1:0] v,
        input int unsigned              out_w,
        input logic                     sat_en
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        logic signed [WIDE_W-1:0] r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat_en) begin
            if (v > hi)      r = hi;
            else if (v < lo) r = lo;
            else             r = v;
        end else begin
            // Keep the low out_w bits and sign-extend them back to WIDE_W.
            r = (v <<< (WIDE_W - out_w)) >>> (WIDE_W - out_w);
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// -----------------------------------------------------------------------------
// nn_mac_unit
// One shared signed multiplier feeding a registered accumulator.
// Each enabled cycle: acc <= acc + ((a * w) >>> SHIFT), the shift being an
// arithmetic (floor) shift of the full-width product.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears acc)
//   i_clear    : synchronous clear of the accumulator (priority over i_en)
//   i_en       : accumulate one product this cycle
//   i_a, i_w   : signed activation and weight operands
//   o_acc      : accumulator value
// -----------------------------------------------------------------------------
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int W_W   = 10,
    parameter int SHIFT = 2,
    parameter int ACC_W = acc_width(IN_W, W_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_en,
    input  logic signed [IN_W-1:0]  i_a,
    input  logic signed [W_W-1:0]   i_w,
    output logic signed [ACC_W-1:0] o_acc
);

    localparam int PROD_W = IN_W + W_W;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shifted;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_prod    = PROD_W'(i_a) * PROD_W'(i_w);
    assign w_shifted = w_prod >>> SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_shifted);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/layer_21_mac.sv
// -----------------------------------------------------------------------------
// layer_21_mac
// Output-side neuron: out1 = fit(sum_k((in_k * W_k) >>> SHIFT) + B), computed
// with one shared multiplier over three MAC cycles.
// Config macro LAYER_MAC_SAT_EN: defined -> acc+B saturates to OUT_W,
// undefined -> acc+B wraps to its low OUT_W bits.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake for in1..in3
//   in1, in2, in3       : signed activations (IN_W)
//   out_valid/out_ready : output handshake for out1
//   out1                : signed result (OUT_W), registered
//   busy                : high while in the MAC state
// Latency: accept edge 0, out_valid high after edge 4.
// -----------------------------------------------------------------------------
module layer_21_mac
    import nn_pkg::*;
#(
    parameter int                     IN_W  = 9,
    parameter int                     W_W   = 10,
    parameter int                     OUT_W = 17,
    parameter int                     SHIFT = 2,
    parameter logic signed [W_W-1:0]   W1    = 10'sh0C3,
    parameter logic signed [W_W-1:0]   W2    = 10'sh3A0,
    parameter logic signed [W_W-1:0]   W3    = 10'sh012,
    parameter logic signed [OUT_W-1:0] B     = 17'sh001F0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in1,
    input  logic signed [IN_W-1:0]  in2,
    input  logic signed [IN_W-1:0]  in3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out1,
    output logic                    busy
);

    localparam int ACC_W = acc_width(IN_W, W_W);
`ifdef LAYER_MAC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t                   r_state;
    logic [1:0]               r_idx;
    logic signed [IN_W-1:0]   r_in1;
    logic signed [IN_W-1:0]   r_in2;
    logic signed [IN_W-1:0]   r_in3;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;
    logic signed [OUT_W-1:0]  r_out1;

    logic                     w_xfer;
    logic                     w_accept;
    logic                     w_mac_en;
    logic signed [IN_W-1:0]   w_a;
    logic signed [W_W-1:0]    w_w;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [WIDE_W-1:0] w_sum;
    logic signed [WIDE_W-1:0] w_fit;

    // The output transfer edge may also accept the next set; this is what
    // gives one result every 5 cycles with both handshakes held high.
    assign w_xfer   = r_out_valid & out_ready;
    assign in_ready = r_in_ready | w_xfer;
    assign w_accept = in_valid & in_ready;
    assign w_mac_en = (r_state == ST_MAC);

    always_comb begin
        w_a = r_in3;
        w_w = W3;
        case (r_idx)
            2'd0: begin
                w_a = r_in1;
                w_w = W1;
            end
            2'd1: begin
                w_a = r_in2;
                w_w = W2;
            end
            default: begin
                w_a = r_in3;
                w_w = W3;
            end
        endcase
    end

    nn_mac_unit #(
        .IN_W  (IN_W),
        .W_W   (W_W),
        .SHIFT (SHIFT),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_accept),
        .i_en    (w_mac_en),
        .i_a     (w_a),
        .i_w     (w_w),
        .o_acc   (w_acc)
    );

    assign w_sum = WIDE_W'(w_acc) + WIDE_W'(B);
    assign w_fit = fit_width(w_sum, OUT_W, SAT_EN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_in3       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out1      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in1      <= in1;
                        r_in2      <= in2;
                        r_in3      <= in3;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_idx == 2'd2) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (!r_out_valid) begin
                        r_out1      <= OUT_W'(w_fit);
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_in1   <= in1;
                            r_in2   <= in2;
                            r_in3   <= in3;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_MAC;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out1      = r_out1;
    assign busy      = r_busy;

endmodule

// File: tb/tb_layer_21_mac.sv
module tb_layer_21_mac;

    logic clk = 1'b0;
    logic rst_n;

    logic               in_valid, in_ready, out_valid, out_ready, busy;
    logic signed [8:0]  in1, in2, in3;
    logic signed [16:0] out1;

    logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic signed [8:0]  b_in1, b_in2, b_in3;
    logic signed [11:0] b_out1;

    int total = 0;
    int bad   = 0;

    int va[50];
    int vb[50];
    int vc[50];

    always #5 clk = ~clk;

    layer_21_mac u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .busy      (busy)
    );

    layer_21_mac #(
        .OUT_W (12),
        .B     (12'sd496)
    ) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in1       (b_in1),
        .in2       (b_in2),
        .in3       (b_in3),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out1      (b_out1),
        .busy      (b_busy)
    );

    // ---------------- reference model ----------------
    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint neuron(input int a1, input int a2, input int a3);
        return floor_div(longint'(a1) * 195, 4) + floor_div(longint'(a2) * -96, 4)
             + floor_div(longint'(a3) * 18, 4) + 496;
    endfunction

    function automatic longint fit(input longint v, input int w);
        longint hi;
        longint lo;
        longint m;
        longint r;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        m  = longint'(1) <<< w;
`ifdef LAYER_MAC_SAT_EN
        if (v > hi)      r = hi;
        else if (v < lo) r = lo;
        else             r = v;
`else
        r = v % m;
        if (r < 0)  r = r + m;
        if (r > hi) r = r - m;
`endif
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a1, input int a2, input int a3);
        in1 = 9'(a1);
        in2 = 9'(a2);
        in3 = 9'(a3);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_bit(tag, in_ready, 1'b1);
    endtask

    // One full transaction with latency, width and value checks.
    task automatic single(input int a1, input int a2, input int a3,
                          input logic signed [16:0] lit, input string tag);
        logic signed [16:0] e;
        e = 17'(fit(neuron(a1, a2, a3), 17));
        drive(a1, a2, a3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_ready({tag, "_rdy"});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in1 = 9'($urandom);
        in2 = 9'($urandom);
        in3 = 9'($urandom);
        chk_bit({tag, "_busy"}, busy, 1'b1);
        chk_bit({tag, "_inrdy0"}, in_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk_bit({tag, "_early_valid"}, out_valid, 1'b0);
            @(negedge clk);
        end
        chk_bit({tag, "_valid"}, out_valid, 1'b1);
        chk_bit({tag, "_busy_done"}, busy, 1'b0);
        chk_val({tag, "_model"}, 32'(out1), 32'(e));
        chk_val({tag, "_lit"}, 32'(out1), 32'(lit));
        @(negedge clk);
        chk_bit({tag, "_one_wide"}, out_valid, 1'b0);
        chk_bit({tag, "_idle_rdy"}, in_ready, 1'b1);
    endtask

    initial begin
        logic signed [16:0] e17;
        logic signed [11:0] e12;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        drive(0, 0, 0);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        b_in1 = '0;
        b_in2 = '0;
        b_in3 = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_val("rst_out1", 32'(out1), 32'sd0);
        chk_bit("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed values
        single(10, 20, -5, 17'sd480, "t480");
        single(0, 0, 0, 17'sd496, "t496");
        single(-256, 0, 0, 17'sh1D130, "tneg");

        // backpressure
        drive(10, 20, -5);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        wait_ready("bp_rdy");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            chk_bit("bp_valid", out_valid, 1'b1);
            chk_val("bp_out1", 32'(out1), 32'sd480);
            chk_bit("bp_inrdy", in_ready, 1'b0);
            in_valid = (c == 3);
            if (c == 3) drive(1, 1, 1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk_bit("bp_release_valid", out_valid, 1'b1);
        @(negedge clk);
        chk_bit("bp_after_valid", out_valid, 1'b0);
        chk_bit("bp_after_rdy", in_ready, 1'b1);
        for (int c = 0; c < 6; c++) begin
            chk_bit("bp_no_second", out_valid, 1'b0);
            @(negedge clk);
        end

        // reset during MAC index 1
        drive(100, -100, 50);
        in_valid = 1'b1;
        wait_ready("rm_rdy");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_bit("rm_valid", out_valid, 1'b0);
        chk_bit("rm_rdy_now", in_ready, 1'b1);
        chk_bit("rm_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        single(10, 20, -5, 17'sd480, "rm_next");

        // narrow output variant
        b_in1 = 9'sd255;
        b_in2 = -9'sd256;
        b_in3 = 9'sd255;
        b_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        e12 = 12'(fit(neuron(255, -256, 255), 12));
        chk_bit("w12_valid", b_out_valid, 1'b1);
        chk_val("w12_model", 32'(b_out1), 32'(e12));
`ifdef LAYER_MAC_SAT_EN
        chk_val("w12_lit", 32'(b_out1), 32'sd2047);
`else
        chk_val("w12_lit", 32'(b_out1), -32'sd262);
`endif
        @(negedge clk);

        // back-to-back random sets
        for (int i = 0; i < 50; i++) begin
            va[i] = int'($urandom_range(0, 511)) - 256;
            vb[i] = int'($urandom_range(0, 511)) - 256;
            vc[i] = int'($urandom_range(0, 511)) - 256;
        end
        out_ready = 1'b1;
        drive(va[0], vb[0], vc[0]);
        in_valid = 1'b1;
        wait_ready("b2b_first_rdy");
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            in1 = 9'($urandom);
            in2 = 9'($urandom);
            in3 = 9'($urandom);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk_bit("b2b_gap", out_valid, 1'b0);
            end
            @(negedge clk);
            e17 = 17'(fit(neuron(va[i], vb[i], vc[i]), 17));
            chk_bit("b2b_valid", out_valid, 1'b1);
            chk_val("b2b_out1", 32'(out1), 32'(e17));
            chk_bit("b2b_rdy", in_ready, 1'b1);
            if (i < 49) drive(va[i+1], vb[i+1], vc[i+1]);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        chk_bit("b2b_end_valid", out_valid, 1'b0);
        chk_bit("b2b_end_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_21_mac.md
Name: layer_21_mac

Overview:
- Output-side neuron: consumes the three hidden-layer activations and reduces them to one signed output. Function: weighted sum, arithmetic shift, bias add.
- Time-multiplexed: one shared multiplier, one product per cycle, instead of the parallel combinational multipliers used on the fan-out side.
- Sits between the hidden-layer activation stage and the PLL loop-filter/controller input.
- Valid/ready handshake on both sides.

Parameters:
- IN_W, 9, signed width of each activation input
- W_W, 10, signed width of each weight
- OUT_W, 17, signed width of the output and of the bias
- SHIFT, 2, arithmetic right shift applied to each product before accumulation
- W1, 10'h0C3 (+195), weight for in1
- W2, 10'h3A0 (-96), weight for in2
- W3, 10'h012 (+18), weight for in3
- B, 17'h001F0 (+496), bias

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in1..in3 valid
- in_ready  out  1  block can accept an input set
- in1  in  IN_W  signed activation 1
- in2  in  IN_W  signed activation 2
- in3  in  IN_W  signed activation 3
- out_valid  out  1  out1 valid
- out_ready  in  1  downstream accepts out1
- out1  out  OUT_W  signed neuron output
- busy  out  1  high in MAC state

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, in_ready=1, out_valid=0, out1=0, busy=0, accumulator=0, index=0.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in1..in3 into registers, clear the accumulator, set index=0, go to MAC.
- MAC:
  - in_ready=0, busy=1.
  - Each cycle: p = in_sel * W_sel, full width IN_W+W_W. Then acc += (p >>> SHIFT), arithmetic, floor toward -inf. Index selects 1, 2, 3.
  - After the index-2 accumulation edge, go to DONE.
  - The accumulator is ACC_W = IN_W+W_W+2 bits and never overflows internally.
- DONE:
  - out_valid=1 and out1 = (acc + B) reduced to OUT_W (see Optional Feature).
  - out1 is registered and stable while out_valid=1 && out_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
- Latency: the accept edge is edge 0; out_valid is high after edge 4 (accept + 3 MAC + result register). If out_ready is held high, a new set is accepted every 5 cycles at most.
- Inputs presented while in_ready=0 are ignored, not queued.
- Upstream must hold in1..in3 stable until accepted.
- Captured inputs are insensitive to input changes after acceptance.
- Reset mid-MAC or mid-DONE: immediate abort, outputs return to reset values, the partial sum is discarded.
- Per-product shift before the sum keeps the block bit-exact with the team's combinational layer golden model. Summing first and shifting once is not equivalent.

Optional Feature:
- Macro: LAYER_MAC_SAT_EN.
- Defined: acc+B is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: acc+B is truncated to its low OUT_W bits, two's-complement wrap.
- Both modes register the result identically, with the same latency.

Decomposition:
- Shared package nn_pkg holds:
  - ACC_W derivation
  - state encoding (IDLE=2'd0, MAC=2'd1, DONE=2'd2)
  - a saturate/truncate function parameterised on widths
- Natural sub-module: nn_mac_unit, holding the registered multiply, shift and accumulate, with clear/enable inputs. The FSM and handshake stay in layer_21_mac.

Test Plan:
- Defaults, in=(10,20,-5), out_ready=1: products 1950, -1920, -90 -> shifted 487, -480, -23 -> out1=480 (17'h001E0), out_valid exactly 4 edges after accept, one cycle wide.
- in=(0,0,0) -> out1=496. Then in=(-256,0,0): -49920>>>2 = -12480, +496 -> out1=-11984 (17'h1D130).
- Backpressure: out_ready=0 for 10 cycles after out_valid. out1 holds 480, in_ready stays 0, and a second in_valid pulse is ignored. Releasing out_ready gives exactly one transfer, then IDLE.
- OUT_W=12, in=(255,-256,255): acc+B=20218.
  - With LAYER_MAC_SAT_EN -> out1=2047.
  - Without -> out1=-262 (12'hEFA).
- Assert rst_n low during MAC index 1: out_valid=0, in_ready=1 immediately, with no residual sum. The next set (10,20,-5) still yields 480.
- Back-to-back sets, with in_valid and out_ready held high: one result every 5 cycles, values match the golden model for 50 random vectors.
